// File: rtl/spectrum_capture_ctrl_pkg.sv
// rtl/spectrum_capture_ctrl_pkg.sv - shared constants, state encoding and decimation helper
package spectrum_pkg;

  localparam int FRAME_LEN = 4096;
  localparam int SAMPLE_W  = 16;
  localparam int DEC_CNT_W = 15;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_EMPTY = 3'd1,
    HOLDOFF    = 3'd2,
    CAPTURE    = 3'd3,
    DONE       = 3'd4
  } state_e;

  // Terminal count of the decimation counter for a ratio of 2^exp.
  function automatic logic [DEC_CNT_W-1:0] decim_mask(input int unsigned exp);
    return DEC_CNT_W'((32'd1 << exp) - 32'd1);
  endfunction

endpackage

// File: rtl/spectrum_capture_ctrl_if.sv
// rtl/spectrum_capture_ctrl_if.sv - control, ADC and FIFO write-side signals of the capture controller
interface spectrum_capture_ctrl_if #(
  parameter int HOLDOFF_W = 16,
  parameter int DECIM_W   = 4
);
  import spectrum_pkg::*;

  logic                 enable;
  logic [DECIM_W-1:0]   decim;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [SAMPLE_W-1:0]  adc_data;
  logic                 fifo_wrempty;
  logic                 fifo_wrfull;
  logic                 wrreq;
  logic [SAMPLE_W-1:0]  wdata;
  logic                 busy;
  logic                 frame_done;
  logic                 overrun;

  modport master (
    input  enable, decim, holdoff, adc_data, fifo_wrempty, fifo_wrfull,
    output wrreq, wdata, busy, frame_done, overrun
  );

  modport slave (
    output enable, decim, holdoff, adc_data, fifo_wrempty, fifo_wrfull,
    input  wrreq, wdata, busy, frame_done, overrun
  );

endinterface

// File: rtl/spectrum_capture_ctrl_decimator.sv
// rtl/spectrum_capture_ctrl_decimator.sv - sample strobe generator, one strobe every 2^decim_s clocks
module spectrum_decimator #(
  parameter int DECIM_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               run_i,
  input  logic [DECIM_W-1:0] decim_s_i,
  output logic               sample_strobe_o
);
  import spectrum_pkg::*;

  logic [DEC_CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic                 hit;

  always_comb begin
    hit             = (dec_cnt_q == decim_mask(32'(decim_s_i)));
    sample_strobe_o = run_i & hit;
    dec_cnt_d       = dec_cnt_q;
    if (clear_i) begin
      dec_cnt_d = '0;
    end else if (run_i) begin
      dec_cnt_d = hit ? '0 : dec_cnt_q + DEC_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dec_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end

endmodule

// File: rtl/spectrum_capture_ctrl.sv
// rtl/spectrum_capture_ctrl.sv - writes whole decimated frames into the spectrum FIFO once it drains
module spectrum_capture_ctrl #(
  parameter int FRAME_LEN = spectrum_pkg::FRAME_LEN,
  parameter int HOLDOFF_W = 16,
  parameter int DECIM_W   = 4
) (
  input logic                     clock,
  input logic                     reset_n,
  spectrum_capture_ctrl_if.master sif
);
  import spectrum_pkg::*;

  localparam int SAMP_W = $clog2(FRAME_LEN) + 1;

  state_e               state_q, state_d;
  logic [HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DECIM_W-1:0]   decim_s_q, decim_s_d;
  logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d;
  logic                 wrreq_q, wrreq_d;
  logic [SAMPLE_W-1:0]  wdata_q, wdata_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;
  logic                 busy;

  logic run, frame_start, strobe, accept, last_write;

  assign run         = (state_q == CAPTURE);
  assign frame_start = (state_q == HOLDOFF) && sif.enable && (hold_cnt_q == '0);
  // A slot that meets a full FIFO is consumed but never written or counted.
  assign accept      = strobe && !sif.fifo_wrfull;
  assign last_write  = accept && (samp_cnt_q == SAMP_W'(FRAME_LEN - 1));

  spectrum_decimator #(.DECIM_W(DECIM_W)) u_decim (
    .clock           (clock),
    .reset_n         (reset_n),
    .clear_i         (frame_start),
    .run_i           (run),
    .decim_s_i       (decim_s_q),
    .sample_strobe_o (strobe)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      decim_s_q    <= '0;
      samp_cnt_q   <= '0;
      wrreq_q      <= 1'b0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      decim_s_q    <= decim_s_d;
      samp_cnt_q   <= samp_cnt_d;
      wrreq_q      <= wrreq_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (sif.enable) state_d = WAIT_EMPTY;
      WAIT_EMPTY: begin
        if (!sif.enable)           state_d = IDLE;
        else if (sif.fifo_wrempty) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (!sif.enable)            state_d = IDLE;
        else if (hold_cnt_q == '0)  state_d = CAPTURE;
      end
      // Enable is ignored here so a started frame is always completed.
      CAPTURE:    if (last_write) state_d = DONE;
      DONE:       state_d = sif.enable ? WAIT_EMPTY : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == HOLDOFF) || (state_q == CAPTURE);
    hold_cnt_d   = hold_cnt_q;
    decim_s_d    = decim_s_q;
    samp_cnt_d   = samp_cnt_q;
    wrreq_d      = 1'b0;
    wdata_d      = wdata_q;
    frame_done_d = (state_q == DONE);
    overrun_d    = overrun_q;

    if ((state_q == WAIT_EMPTY) && sif.enable && sif.fifo_wrempty) begin
      decim_s_d  = sif.decim;
      hold_cnt_d = sif.holdoff;
    end
    if ((state_q == HOLDOFF) && (hold_cnt_q != '0)) begin
      hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
    end
    if (frame_start) begin
      samp_cnt_d = '0;
    end
    if (accept) begin
      wrreq_d    = 1'b1;
      wdata_d    = sif.adc_data;
      samp_cnt_d = samp_cnt_q + SAMP_W'(1);
    end
    if (!sif.enable) begin
      overrun_d = 1'b0;
    end else if (strobe && sif.fifo_wrfull) begin
      overrun_d = 1'b1;
    end
  end

  assign sif.wrreq      = wrreq_q;
  assign sif.wdata      = wdata_q;
  assign sif.busy       = busy;
  assign sif.frame_done = frame_done_q;
  assign sif.overrun    = overrun_q;

endmodule

// File: tb/tb_spectrum_capture_ctrl.sv
// tb/tb_spectrum_capture_ctrl.sv - scoreboard bench for the spectrum capture controller
module tb_spectrum_capture_ctrl;
  import spectrum_pkg::*;

  localparam int FL = 4096;

  typedef struct {
    int          e;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spectrum_capture_ctrl_if #(.HOLDOFF_W(16), .DECIM_W(4)) sif ();

  spectrum_capture_ctrl #(.FRAME_LEN(FL), .HOLDOFF_W(16), .DECIM_W(4)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .sif     (sif)
  );

  int          edge_n = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         wq[$];
  int          dq[$];
  int          busy_lo = 0;
  int          busy_hi = 0;
  bit          full_edges[int];
  logic [15:0] salt = 16'h0000;
  int          fr_edges[FL];

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [15:0] adc_fn(input int e);
    return 16'(e) ^ salt;
  endfunction

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ADC ramp/scramble and FIFO-full pattern; values driven after edge n are sampled at edge n+1.
  initial begin
    sif.adc_data    = adc_fn(1);
    sif.fifo_wrfull = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sif.adc_data    = adc_fn(edge_n + 1);
      sif.fifo_wrfull = (full_edges.exists(edge_n + 1) != 0);
    end
  end

  always @(negedge clk) begin
    int  n;
    wr_t w;
    int  de;
    if (edge_n >= 1) begin
      n = edge_n;
      if (wq.size() > 0 && wq[0].e < n) begin
        chk(1'b0, "wr_missing_edge", n, wq[0].e);
        w = wq.pop_front();
      end
      if (sif.wrreq === 1'b1) begin
        if (wq.size() == 0) begin
          chk(1'b0, "wr_unexpected_edge", n, -1);
        end else begin
          w = wq.pop_front();
          chk(w.e == n, "wr_edge", n, w.e);
          chk(sif.wdata === w.d, "wr_data", sif.wdata, w.d);
        end
      end
      if (dq.size() > 0 && dq[0] < n) begin
        chk(1'b0, "done_missing_edge", n, dq[0]);
        de = dq.pop_front();
      end
      if (sif.frame_done === 1'b1) begin
        if (dq.size() == 0) begin
          chk(1'b0, "done_unexpected_edge", n, -1);
        end else begin
          de = dq.pop_front();
          chk(de == n, "done_edge", n, de);
        end
      end
      chk(sif.busy === ((n >= busy_lo && n < busy_hi) ? 1'b1 : 1'b0), "busy", sif.busy,
          (n >= busy_lo && n < busy_hi) ? 1 : 0);
    end
  end

  // Frame schedule from the rules: slot j is decided at e0 + holdoff + 1 + (j+1)*2^decim.
  task automatic start_frame(input int d, input int h, input bit from_idle,
                             input int full_j, input int full_n);
    int  e0, base, r, j, k, dd;
    wr_t w;
    r = 1 << d;
    sif.decim        = 4'(d);
    sif.holdoff      = 16'(h);
    sif.fifo_wrempty = 1'b1;
    if (from_idle) sif.enable = 1'b1;
    e0   = edge_n + 1 + (from_idle ? 1 : 0);
    base = e0 + h + 1;
    j  = 0;
    k  = 0;
    dd = base;
    while (k < FL) begin
      dd = base + (j + 1) * r;
      if (j >= full_j && j < full_j + full_n) begin
        full_edges[dd] = 1'b1;
      end else begin
        w.e = dd;
        w.d = adc_fn(dd);
        wq.push_back(w);
        fr_edges[k] = dd;
        k++;
      end
      j++;
    end
    dq.push_back(dd + 1);
    busy_lo = e0;
    busy_hi = dd;
    step(from_idle ? 2 : 1);
    sif.fifo_wrempty = 1'b0;
    sif.decim        = 4'($urandom);
    sif.holdoff      = 16'($urandom);
  endtask

  task automatic wait_frame(input string nm);
    int t;
    t = 0;
    while ((wq.size() > 0 || dq.size() > 0) && t < 40000) begin
      step(1);
      t++;
    end
    chk(wq.size() == 0 && dq.size() == 0, nm, wq.size() + dq.size(), 0);
    wq.delete();
    dq.delete();
    step(1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1, "time limit");
  end

  initial begin
    int  r_edge;
    wr_t w;
    int  de;
    sif.enable       = 1'b0;
    sif.decim        = '0;
    sif.holdoff      = '0;
    sif.fifo_wrempty = 1'b0;
    reset_n          = 1'b0;
    step(3);
    chk(sif.wrreq === 1'b0, "rst_wrreq", sif.wrreq, 0);
    chk(sif.busy === 1'b0, "rst_busy", sif.busy, 0);
    chk(sif.frame_done === 1'b0, "rst_frame_done", sif.frame_done, 0);
    chk(sif.overrun === 1'b0, "rst_overrun", sif.overrun, 0);
    chk(sif.wdata === 16'h0000, "rst_wdata", sif.wdata, 0);
    reset_n    = 1'b1;
    sif.enable = 1'b1;
    step(2);

    // Ramp, decim 0, holdoff 0: back-to-back writes.
    start_frame(0, 0, 1'b0, 0, 0);
    wait_frame("t1_frame_complete");

    // Decim 3, holdoff 10.
    salt = 16'($urandom);
    start_frame(3, 10, 1'b0, 0, 0);
    wait_frame("t2_frame_complete");

    // Five full slots mid-frame.
    salt = 16'($urandom);
    chk(sif.overrun === 1'b0, "t3_overrun_before", sif.overrun, 0);
    start_frame(0, $urandom_range(0, 20), 1'b0, $urandom_range(100, 3900), 5);
    wait_frame("t3_frame_complete");
    chk(sif.overrun === 1'b1, "t3_overrun_set", sif.overrun, 1);
    sif.enable = 1'b0;
    step(1);
    chk(sif.overrun === 1'b0, "t3_overrun_clear", sif.overrun, 0);
    sif.enable = 1'b1;
    step(2);

    // Enable drops at write 100; frame still completes, then stays idle.
    salt = 16'($urandom);
    start_frame(0, $urandom_range(0, 20), 1'b0, 0, 0);
    while (edge_n < fr_edges[99]) step(1);
    sif.enable = 1'b0;
    wait_frame("t4_frame_complete");
    sif.fifo_wrempty = 1'b1;
    step(40);
    chk(sif.busy === 1'b0, "t4_idle_busy", sif.busy, 0);
    chk(wq.size() == 0, "t4_idle_no_frame", wq.size(), 0);
    salt = 16'($urandom);
    start_frame($urandom_range(0, 1), $urandom_range(0, 20), 1'b1, 0, 0);
    wait_frame("t4_idle_start_frame_complete");

    // Reset at write 2000 after one dropped slot.
    salt = 16'($urandom);
    start_frame(0, $urandom_range(0, 20), 1'b0, 500, 1);
    while (edge_n < fr_edges[1999]) step(1);
    chk(sif.overrun === 1'b1, "t5_overrun_before_reset", sif.overrun, 1);
    reset_n = 1'b0;
    r_edge  = edge_n + 1;
    while (wq.size() > 0 && wq[$].e >= r_edge) w = wq.pop_back();
    while (dq.size() > 0 && dq[$] >= r_edge) de = dq.pop_back();
    if (busy_hi > r_edge) busy_hi = r_edge;
    step(1);
    chk(sif.wrreq === 1'b0, "t5_reset_wrreq", sif.wrreq, 0);
    chk(sif.busy === 1'b0, "t5_reset_busy", sif.busy, 0);
    chk(sif.overrun === 1'b0, "t5_reset_overrun", sif.overrun, 0);
    reset_n = 1'b1;
    step(30);
    chk(sif.busy === 1'b0, "t6_no_empty_busy", sif.busy, 0);
    salt = 16'($urandom);
    start_frame($urandom_range(0, 1), $urandom_range(0, 20), 1'b0, 0, 0);
    wait_frame("t5_restart_frame_complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
